// File: rtl/vco_phase_gen.sv
// vco_phase_gen: multi-channel VCO phase source, FCW accumulator or looped table playback per channel.
// Latency: one clk from the enabling edge to registered p/wrap; first enabled cycle shows fcw>>FRAC_WIDTH or table[0].
// Backpressure: none, consumer samples p every cycle. Macro VCO_PLAYBACK_EN compiles in table, pointers and playback mode.
module vco_phase_gen #(
   parameter int PHASE_WIDTH = 11,
   parameter int FRAC_WIDTH  = 5,
   parameter int NUM_CH      = 2,
   parameter int DEPTH       = 1024,
   localparam int ACC_W      = PHASE_WIDTH + FRAC_WIDTH,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CH-1:0]             enb_n,
   input  logic                          mode,
   input  logic                          fcw_we,
   input  logic [2:0]                    fcw_ch,
   input  logic [ACC_W-1:0]              fcw_in,
   input  logic                          tbl_we,
   input  logic [AW-1:0]                 tbl_addr,
   input  logic [PHASE_WIDTH-1:0]        tbl_data,
   input  logic [AW-1:0]                 play_len,
   output logic [NUM_CH*PHASE_WIDTH-1:0] p,
   output logic [NUM_CH-1:0]             wrap
);

   logic [ACC_W-1:0]              acc_q   [NUM_CH];
   logic [ACC_W-1:0]              acc_d   [NUM_CH];
   logic [ACC_W-1:0]              fcw_q   [NUM_CH];
   logic [ACC_W-1:0]              fcw_d   [NUM_CH];
   logic [ACC_W:0]                acc_sum [NUM_CH];
   logic [NUM_CH*PHASE_WIDTH-1:0] p_q, p_d;
   logic [NUM_CH-1:0]             wrap_q, wrap_d;
   logic                          mode_chg;

`ifdef VCO_PLAYBACK_EN
   logic                   mode_q;
   logic [AW-1:0]          ptr_q   [NUM_CH];
   logic [AW-1:0]          ptr_d   [NUM_CH];
   logic [PHASE_WIDTH-1:0] tbl_mem [DEPTH];

   // A mode flip (against last cycle's mode) restarts every channel from zero.
   assign mode_chg = (mode != mode_q);
`else
   // Accumulator-only build: mode is pinned to 0 and the table inputs have no sink.
   assign mode_chg = 1'b0;
   wire unused_pb = ^{mode, tbl_we, tbl_addr, tbl_data, play_len};
`endif

   // Per-channel carry-extended sum and FCW write decode (out-of-range channel writes drop).
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         acc_sum[c] = {1'b0, acc_q[c]} + {1'b0, fcw_q[c]};
         fcw_d[c]   = fcw_q[c];
         if (fcw_we && (32'(fcw_ch) == c)) begin
            fcw_d[c] = fcw_in;
         end
      end
   end

   // Next-state per channel: mode-change clear, disabled hold, accumulate or table playback.
   always_comb begin
      p_d    = '0;
      wrap_d = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         acc_d[c] = acc_q[c];
`ifdef VCO_PLAYBACK_EN
         ptr_d[c] = ptr_q[c];
`endif
         if (mode_chg) begin
            acc_d[c] = '0;
`ifdef VCO_PLAYBACK_EN
            ptr_d[c] = '0;
`endif
         end else if (!enb_n[c]) begin
`ifdef VCO_PLAYBACK_EN
            if (mode) begin
               // Pointer above a shortened loop free-runs to DEPTH-1 and rolls over silently.
               p_d[c*PHASE_WIDTH +: PHASE_WIDTH] = tbl_mem[ptr_q[c]];
               if (ptr_q[c] == play_len) begin
                  ptr_d[c]  = '0;
                  wrap_d[c] = 1'b1;
               end else begin
                  ptr_d[c]  = ptr_q[c] + AW'(1);
               end
            end else begin
`endif
               acc_d[c]  = acc_sum[c][ACC_W-1:0];
               p_d[c*PHASE_WIDTH +: PHASE_WIDTH] = acc_sum[c][ACC_W-1 -: PHASE_WIDTH];
               wrap_d[c] = acc_sum[c][ACC_W];
`ifdef VCO_PLAYBACK_EN
            end
`endif
         end
      end
   end

   // Accumulator, FCW and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            acc_q[c] <= '0;
            fcw_q[c] <= '0;
         end
         p_q    <= '0;
         wrap_q <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            acc_q[c] <= acc_d[c];
            fcw_q[c] <= fcw_d[c];
         end
         p_q    <= p_d;
         wrap_q <= wrap_d;
      end
   end

`ifdef VCO_PLAYBACK_EN
   // Read pointers; mode is tracked through reset so the first cycle after reset plays table[0].
   always_ff @(posedge clk) begin
      mode_q <= mode;
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            ptr_q[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            ptr_q[c] <= ptr_d[c];
         end
      end
   end

   // Shared table storage, not reset; same-cycle reads see the old word.
   always_ff @(posedge clk) begin
      if (!rst && tbl_we) begin
         tbl_mem[tbl_addr] <= tbl_data;
      end
   end
`endif

   assign p    = p_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_vco_phase_gen.sv
// Bench for vco_phase_gen: vector table, hand sequences for mode/reset/table corners,
// then randomized traffic against a behavioural model. Playback checks follow VCO_PLAYBACK_EN.
`timescale 1ns/1ps
module tb_vco_phase_gen;
   localparam int PW    = 11;
   localparam int NCH   = 2;
   localparam int DEPTH = 1024;
`ifdef VCO_PLAYBACK_EN
   localparam bit PLAYBACK = 1'b1;
`else
   localparam bit PLAYBACK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  enb_n;
   logic        mode;
   logic        fcw_we;
   logic [2:0]  fcw_ch;
   logic [15:0] fcw_in;
   logic        tbl_we;
   logic [9:0]  tbl_addr;
   logic [10:0] tbl_data;
   logic [9:0]  play_len;
   logic [21:0] p;
   logic [1:0]  wrap;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural reference state
   int acc_m [NCH];
   int fcw_m [NCH];
   int ptr_m [NCH];
   int p_m   [NCH];
   bit wrap_m[NCH];
   int tbl_m [DEPTH];
   bit mode_prev_m;

   vco_phase_gen dut (
      .clk(clk), .rst(rst), .enb_n(enb_n), .mode(mode),
      .fcw_we(fcw_we), .fcw_ch(fcw_ch), .fcw_in(fcw_in),
      .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
      .play_len(play_len), .p(p), .wrap(wrap)
   );

   always #10 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // One clock of the reference: phase = accumulator/32, accumulator modulo 2^16, carry = wrap.
   task automatic model_step();
      bit chg;
      int s;
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin
            acc_m[c] = 0; fcw_m[c] = 0; ptr_m[c] = 0; p_m[c] = 0; wrap_m[c] = 0;
         end
         mode_prev_m = mode;
         return;
      end
      chg = PLAYBACK && (mode != mode_prev_m);
      for (int c = 0; c < NCH; c++) begin
         p_m[c] = 0;
         wrap_m[c] = 0;
         if (chg) begin
            acc_m[c] = 0;
            ptr_m[c] = 0;
         end else if (!enb_n[c]) begin
            if (PLAYBACK && mode) begin
               p_m[c] = tbl_m[ptr_m[c]];
               if (ptr_m[c] == int'(play_len)) begin
                  ptr_m[c] = 0;
                  wrap_m[c] = 1;
               end else begin
                  ptr_m[c] = (ptr_m[c] + 1) % DEPTH;
               end
            end else begin
               s = acc_m[c] + fcw_m[c];
               wrap_m[c] = (s >= 65536);
               acc_m[c] = s % 65536;
               p_m[c] = acc_m[c] / 32;
            end
         end
      end
      if (fcw_we && fcw_ch < NCH) fcw_m[fcw_ch] = fcw_in;
      if (PLAYBACK && tbl_we) tbl_m[tbl_addr] = tbl_data;
      mode_prev_m = mode;
   endtask

   task automatic tick(input string tag);
      logic [21:0] ep;
      logic [1:0]  ew;
      @(posedge clk);
      model_step();
      #1;
      for (int c = 0; c < NCH; c++) begin
         ep[c*PW +: PW] = PW'(p_m[c]);
         ew[c] = wrap_m[c];
      end
      chk({tag, " model p"}, p, ep);
      chk({tag, " model wrap"}, wrap, ew);
   endtask

   typedef struct {
      bit        rst;
      bit [1:0]  enb_n;
      bit        fcw_we;
      bit [2:0]  fcw_ch;
      bit [15:0] fcw_in;
      int        exp_p0;
      int        exp_p1;
      bit [1:0]  exp_wrap;
   } vec_t;

   vec_t vecs[$];

   initial begin
      rst = 1'b1; enb_n = 2'b11; mode = 1'b0; fcw_we = 1'b0; fcw_ch = 3'd0; fcw_in = 16'd0;
      tbl_we = 1'b0; tbl_addr = 10'd0; tbl_data = 11'd0; play_len = 10'd0;

      // Accumulator wrap with an enable gap, then FCW update and illegal channel
      vecs.push_back('{1, 2'b11, 0, 0, 16'h0000, 0, 0, 2'b00});
      vecs.push_back('{0, 2'b11, 1, 0, 16'h0800, 0, 0, 2'b00});
      for (int k = 1; k <= 5; k++) vecs.push_back('{0, 2'b10, 0, 0, 16'h0, k*64, 0, 2'b00});
      vecs.push_back('{0, 2'b11, 1, 5, 16'hFFFF, 0, 0, 2'b00});
      for (int g = 0; g < 4; g++) vecs.push_back('{0, 2'b11, 0, 0, 16'h0, 0, 0, 2'b00});
      for (int k = 6; k <= 33; k++)
         vecs.push_back('{0, 2'b10, 0, 0, 16'h0, (k*64) % 2048, 0, (k == 32) ? 2'b01 : 2'b00});
      vecs.push_back('{1, 2'b10, 0, 0, 16'h0000, 0, 0, 2'b00});
      vecs.push_back('{0, 2'b10, 0, 0, 16'h0000, 0, 0, 2'b00});
      vecs.push_back('{0, 2'b11, 1, 0, 16'h0800, 0, 0, 2'b00});
      vecs.push_back('{0, 2'b11, 1, 1, 16'h1000, 0, 0, 2'b00});
      vecs.push_back('{0, 2'b10, 0, 0, 16'h0, 64, 0, 2'b00});
      vecs.push_back('{0, 2'b10, 0, 0, 16'h0, 128, 0, 2'b00});
      vecs.push_back('{0, 2'b10, 1, 0, 16'h0040, 192, 0, 2'b00});
      vecs.push_back('{0, 2'b10, 1, 5, 16'hFFFF, 194, 0, 2'b00});
      vecs.push_back('{0, 2'b10, 0, 0, 16'h0, 196, 0, 2'b00});
      vecs.push_back('{0, 2'b10, 0, 0, 16'h0, 198, 0, 2'b00});
      vecs.push_back('{0, 2'b00, 0, 0, 16'h0, 200, 128, 2'b00});
      vecs.push_back('{0, 2'b00, 0, 0, 16'h0, 202, 256, 2'b00});

      tick("reset");
      chk("reset p", p, 64'd0);
      chk("reset wrap", wrap, 64'd0);

      foreach (vecs[i]) begin
         rst = vecs[i].rst; enb_n = vecs[i].enb_n; fcw_we = vecs[i].fcw_we;
         fcw_ch = vecs[i].fcw_ch; fcw_in = vecs[i].fcw_in;
         tick("vec");
         chk($sformatf("vec%0d p0", i), 64'(p[10:0]), 64'(vecs[i].exp_p0));
         chk($sformatf("vec%0d p1", i), 64'(p[21:11]), 64'(vecs[i].exp_p1));
         chk($sformatf("vec%0d wrap", i), 64'(wrap), 64'(vecs[i].exp_wrap));
      end
      fcw_we = 1'b0;

`ifdef VCO_PLAYBACK_EN
      // Playback loop, reset at ptr=2, read-during-write
      rst = 1'b1; enb_n = 2'b11; tick("pb reset"); rst = 1'b0;
      tbl_we = 1'b1;
      for (int a = 0; a < 4; a++) begin
         tbl_addr = 10'(a); tbl_data = 11'(5 + a); tick("pb load");
      end
      tbl_we = 1'b0; play_len = 10'd3; mode = 1'b1; enb_n = 2'b00;
      tick("pb clear");
      chk("pb mode-clear p", p, 64'd0);
      for (int k = 0; k < 6; k++) begin
         tick("pb loop");
         chk("pb loop p", p, {42'd0, 11'(5 + k % 4), 11'(5 + k % 4)});
         chk("pb loop wrap", wrap, (k % 4 == 3) ? 64'd3 : 64'd0);
      end
      rst = 1'b1; tick("pb rst"); rst = 1'b0;
      chk("pb rst p", p, 64'd0);
      chk("pb rst wrap", wrap, 64'd0);
      for (int k = 0; k < 4; k++) begin
         tick("pb restart");
         chk("pb restart p0", 64'(p[10:0]), 64'(5 + k));
      end
      chk("pb restart wrap", wrap, 64'd3);
      tbl_we = 1'b1; tbl_addr = 10'd0; tbl_data = 11'd9;
      tick("pb rdw");
      chk("pb rdw old data", 64'(p[10:0]), 64'd5);
      tbl_we = 1'b0;
      for (int k = 0; k < 4; k++) tick("pb rdw run");
      chk("pb rdw new data", 64'(p[10:0]), 64'd9);
      mode = 1'b0;
`endif

      // Mode switch mid-run at p0=640
      rst = 1'b1; enb_n = 2'b11; tick("ms reset"); rst = 1'b0;
      fcw_we = 1'b1; fcw_ch = 3'd0; fcw_in = 16'h0800; tick("ms load"); fcw_we = 1'b0;
      enb_n = 2'b10;
      for (int k = 0; k < 10; k++) tick("ms run");
      chk("ms p0 before switch", 64'(p[10:0]), 64'd640);
      mode = 1'b1;
      tick("ms switch");
`ifdef VCO_PLAYBACK_EN
      chk("ms switch p", p, 64'd0);
      chk("ms switch wrap", wrap, 64'd0);
      tick("ms after");
      chk("ms table0", 64'(p[10:0]), 64'd9);
`else
      chk("ms ignored p0", 64'(p[10:0]), 64'd704);
      tick("ms after");
      chk("ms ignored p0 next", 64'(p[10:0]), 64'd768);
`endif
      mode = 1'b0;

      // Randomized traffic
      rst = 1'b1; enb_n = 2'b11; tick("rnd reset"); rst = 1'b0;
      if (PLAYBACK) begin
         tbl_we = 1'b1;
         for (int a = 0; a < DEPTH; a++) begin
            tbl_addr = 10'(a); tbl_data = 11'($urandom); tick("rnd fill");
         end
         tbl_we = 1'b0;
      end
      for (int n = 0; n < 3000; n++) begin
         rst    = ($urandom_range(199) == 0);
         enb_n  = 2'($urandom);
         if ($urandom_range(49) == 0) mode = ~mode;
         fcw_we = ($urandom_range(7) == 0);
         fcw_ch = 3'($urandom);
         fcw_in = 16'($urandom);
         tbl_we = ($urandom_range(3) == 0);
         tbl_addr = 10'($urandom_range(7));
         tbl_data = 11'($urandom);
         if ($urandom_range(99) == 0) play_len = 10'($urandom_range(15));
         tick("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
